// File: rtl/req_channel.sv
// req_channel: one output channel of the request presenter.
// Takes a request ID while idle, then emits a fixed BURST_BEATS-long
// AXI-Stream burst. Each beat carries the ID in the top bits and the
// beat index in bits [15:0].
// DATA_WIDTH must be at least REQ_ID_WIDTH + 16 so that the ID field and
// the index field do not overlap.
// Optional feature macro: REQ_CHANNEL_STATS_EN adds a saturating counter
// of accepted requests. Without it, req_count is held at zero.
module req_channel #(
    parameter int REQ_ID_WIDTH = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int BURST_BEATS  = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [REQ_ID_WIDTH-1:0] req_id,
    input  logic                    req_id_valid,
    output logic                    ready,
    output logic [DATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic                    M_AXIS_TVALID,
    output logic                    M_AXIS_TLAST,
    input  logic                    M_AXIS_TREADY,
    output logic [31:0]             req_count
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [15:0] LAST_BEAT = 16'(BURST_BEATS - 1);

    state_t                  state_q, state_d;
    logic [REQ_ID_WIDTH-1:0] id_q, id_d;
    logic [15:0]             beat_q, beat_d;
    logic                    accept;
    logic                    handshake;
    logic                    last_beat;

    // Next-state logic: latch the ID on accept, step the beat index on
    // each handshake, and return to IDLE after the final beat is taken.
    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        beat_d    = beat_q;
        accept    = (state_q == IDLE) && req_id_valid;
        handshake = (state_q == BURST) && M_AXIS_TREADY;
        last_beat = (beat_q == LAST_BEAT);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    id_d    = req_id;
                    beat_d  = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (handshake) begin
                    if (last_beat) begin
                        state_d = IDLE;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset drops any burst in progress.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            id_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            beat_q  <= beat_d;
        end
    end

    // Outputs decode only from registered state, so there is no
    // combinational path from req_id_valid or TREADY to ready or TVALID.
    always_comb begin
        ready         = (state_q == IDLE);
        M_AXIS_TVALID = (state_q == BURST);
        M_AXIS_TLAST  = (state_q == BURST) && (beat_q == LAST_BEAT);
        M_AXIS_TDATA  = '0;
        if (state_q == BURST) begin
            M_AXIS_TDATA[DATA_WIDTH-1 -: REQ_ID_WIDTH] = id_q;
            M_AXIS_TDATA[15:0]                         = beat_q;
        end
    end

`ifdef REQ_CHANNEL_STATS_EN
    logic [31:0] req_count_q, req_count_d;

    // Count accepted requests, saturating at all-ones.
    always_comb begin
        req_count_d = req_count_q;
        if (accept && (req_count_q != 32'hFFFF_FFFF)) begin
            req_count_d = req_count_q + 32'd1;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            req_count_q <= '0;
        end else begin
            req_count_q <= req_count_d;
        end
    end

    assign req_count = req_count_q;
`else
    assign req_count = 32'd0;
`endif

endmodule
